// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter. The CPU stores bytes to DATA_ADDR, which are
// queued in a 4-entry FIFO and shifted out on `tx` as asynchronous serial
// frames (start bit, 8 data bits LSB first, optional even parity, stop bit).
// A status byte at STAT_ADDR reports FIFO occupancy, a sticky overflow flag and
// the transmitter busy state; writing STAT_ADDR with din[3]=1 clears overflow.
//
// Configuration:
//   UART_TX_PARITY_EN  when defined, an even-parity bit follows the data bits
//                      (8E1, 11-bit frame). Undefined: 8N1, 10-bit frame.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (default 434 = 50 MHz / 115200)
//   DATA_ADDR     write address of the transmit data register
//   STAT_ADDR     read address of the status byte, write address for clearing
//
// Ports:
//   clk      system clock (single clock domain, shared with the CPU)
//   rst      synchronous, active-high reset
//   addr     CPU address bus
//   we       CPU write strobe, one cycle per store
//   din      CPU write data
//   rd_hit   registered: previous-cycle addr was DATA_ADDR or STAT_ADDR
//   rd_data  registered read data, valid when rd_hit=1
//   tx       serial output, idle high, driven from a register
//   busy     high whenever the transmit FSM is not idle
//
// Status byte: {1'b0, count[2:0], overflow, empty, full, busy}
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [15:0] DATA_ADDR    = 16'd997,
  parameter logic [15:0] STAT_ADDR    = 16'd996
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic        rd_hit,
  output logic [7:0]  rd_data,
  output logic        tx,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Baud counter sizing. Guard the degenerate CLKS_PER_BIT=1 case so the
  // counter is never zero bits wide.
  // ---------------------------------------------------------------------------
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // FSM state encoding. The PARITY state only exists when parity is enabled.
  // ---------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t state;
  state_t state_next;

  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_next;
  logic [7:0]        data_reg;
  logic              tx_next;
  logic              baud_zero;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       overflow;

  logic       full;
  logic       empty;
  logic       data_wr;
  logic       stat_wr;
  logic       push;
  logic       pop;
  logic       ovf_set;
  logic       ovf_clr;
  logic [7:0] status;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);

  assign data_wr = we && (addr == DATA_ADDR);
  assign stat_wr = we && (addr == STAT_ADDR);

  // A pop in the same cycle frees a slot, so a store to a full FIFO is still
  // accepted when the transmitter is taking the head byte at that edge.
  assign push    = data_wr && (!full || pop);
  assign ovf_set = data_wr && full && !pop;
  assign ovf_clr = stat_wr && din[3];

  assign busy    = (state != S_IDLE);
  assign status  = {1'b0, count, overflow, empty, full, busy};

  // ---------------------------------------------------------------------------
  // FIFO storage write port
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; emptiness is tracked entirely by
  // count and the pointers, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and sticky overflow
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all flops update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end

      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      // Setting wins over clearing when both happen in the same cycle.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register read port: one cycle of latency, no side effects on FIFO state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hit  <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_hit  <= (addr == DATA_ADDR) || (addr == STAT_ADDR);
      rd_data <= (addr == STAT_ADDR) ? status : 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      data_reg <= 8'h00;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      // tx follows the current state one cycle later, which keeps every bit
      // exactly CLKS_PER_BIT cycles long while removing any combinational
      // path to the pin.
      tx       <= tx_next;
      if (pop) begin
        data_reg <= fifo_mem[rd_ptr];
      end
    end
  end

  assign baud_zero = (baud_cnt == '0);

  // ---------------------------------------------------------------------------
  // Transmit FSM: next state, baud/bit counters, pop request and line level
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    pop        = 1'b0;
    tx_next    = 1'b1;

    unique case (state)
      S_IDLE: begin
        tx_next = 1'b1;
        // count is registered, so a byte stored this cycle is only seen (and
        // popped) on the following cycle.
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_START;
          baud_next  = BAUD_LOAD;
        end
      end

      S_START: begin
        tx_next = 1'b0;
        if (baud_zero) begin
          state_next = S_DATA;
          baud_next  = BAUD_LOAD;
          bit_next   = 3'd0;
        end else begin
          baud_next  = baud_cnt - BAUD_W'(1);
        end
      end

      S_DATA: begin
        tx_next = data_reg[bit_idx];
        if (baud_zero) begin
          baud_next = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        // Even parity: the parity bit makes the total count of ones even.
        tx_next = ^data_reg;
        if (baud_zero) begin
          state_next = S_STOP;
          baud_next  = BAUD_LOAD;
        end else begin
          baud_next  = baud_cnt - BAUD_W'(1);
        end
      end
`endif

      S_STOP: begin
        tx_next = 1'b1;
        if (baud_zero) begin
          baud_next = BAUD_LOAD;
          // Chain straight into the next start bit when more data is queued,
          // so back-to-back bytes leave no idle gap on the line.
          if (!empty) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
        baud_next  = '0;
        bit_next   = 3'd0;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4. Inputs are driven and
// outputs sampled on the falling clock edge. Expected line levels come from a
// small frame model (start, data LSB first, optional even parity, stop).
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam int          CPB       = 4;
  localparam logic [15:0] DATA_ADDR = 16'd997;
  localparam logic [15:0] STAT_ADDR = 16'd996;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  din;
  logic        rd_hit;
  logic [7:0]  rd_data;
  logic        tx;
  logic        busy;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q [8];

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_ADDR   (DATA_ADDR),
    .STAT_ADDR   (STAT_ADDR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .we     (we),
    .din    (din),
    .rd_hit (rd_hit),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected line level for bit j of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // All tasks below start and end on a falling edge.
  task automatic write(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    we   = 1'b1;
    din  = d;
    @(negedge clk);
    we   = 1'b0;
    addr = 16'd0;
    din  = 8'h00;
  endtask

  task automatic read(input string tag, input logic [15:0] a,
                      input logic exp_hit, input logic [7:0] exp_data);
    addr = a;
    @(negedge clk);
    check({tag, "_hit"}, rd_hit, exp_hit);
    check({tag, "_data"}, rd_data, exp_data);
    addr = 16'd0;
  endtask

  // Wait for a start bit, check n contiguous frames from exp_q at mid-bit,
  // then check that the line stays idle afterwards.
  task automatic monitor_frames(input string tag, input int n);
    int found;
    int lows;
    int f;
    int j;
    found = 0;
    lows  = 0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1;
        break;
      end
    end
    check({tag, "_start_seen"}, found, 1);
    if (found != 0) begin
      for (int cyc = 0; cyc < n * FB * CPB; cyc++) begin
        if (cyc != 0) @(negedge clk);
        if (cyc % CPB == CPB / 2) begin
          f = cyc / (FB * CPB);
          j = (cyc / CPB) % FB;
          check($sformatf("%s_f%0d_b%0d", tag, f, j), tx, exp_bit(exp_q[f], j));
        end
      end
      for (int k = 0; k < 2 * FB * CPB; k++) begin
        @(negedge clk);
        if (tx !== 1'b1) lows++;
      end
      check({tag, "_idle_after"}, lows, 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    we   = 1'b0;
    addr = 16'd0;
    din  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_hit", rd_hit, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    read("rst_status", STAT_ADDR, 1'b1, 8'h04);
    read("data_read", DATA_ADDR, 1'b1, 8'h00);

    // Neighbouring addresses do nothing
    write(16'd998, 8'h55);
    write(16'd999, 8'h66);
    read("addr995", 16'd995, 1'b0, 8'h00);
    read("nopush_status", STAT_ADDR, 1'b1, 8'h04);
    check("nopush_busy", busy, 1'b0);

    // Cycle-exact single frame of 8'hA5; c counts edges after the write edge
    write(DATA_ADDR, 8'hA5);
    for (int c = 1; c <= FB * CPB + 4; c++) begin
      logic exp_tx;
      @(negedge clk);
      if (c < 2 || c - 2 >= FB * CPB) exp_tx = 1'b1;
      else                            exp_tx = exp_bit(8'hA5, (c - 2) / CPB);
      check($sformatf("a5_tx_c%0d", c), tx, exp_tx);
      check($sformatf("a5_busy_c%0d", c), busy, (c >= 1 && c <= FB * CPB));
    end

    // Five back-to-back bytes, overflow on a sixth, then clear
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33;
    exp_q[3] = 8'h44; exp_q[4] = 8'h55;
    fork
      monitor_frames("b2b", 5);
      begin
        addr = DATA_ADDR;
        we   = 1'b1;
        for (int i = 0; i < 5; i++) begin
          din = exp_q[i];
          @(negedge clk);
        end
        we   = 1'b0;
        din  = 8'h00;
        read("b2b_full", STAT_ADDR, 1'b1, 8'h43);
        write(DATA_ADDR, 8'h66);
        read("b2b_ovf", STAT_ADDR, 1'b1, 8'h4B);
        write(STAT_ADDR, 8'h08);
        read("b2b_clr", STAT_ADDR, 1'b1, 8'h43);
      end
    join
    read("b2b_done", STAT_ADDR, 1'b1, 8'h04);

    // Status during an active frame with one byte still queued
    exp_q[0] = 8'hC3; exp_q[1] = 8'h3C;
    fork
      monitor_frames("stat", 2);
      begin
        addr = DATA_ADDR;
        we   = 1'b1;
        din  = exp_q[0];
        @(negedge clk);
        din  = exp_q[1];
        @(negedge clk);
        we   = 1'b0;
        din  = 8'h00;
        read("stat_active", STAT_ADDR, 1'b1, 8'h11);
      end
    join

    // Parity sample bytes (odd and even number of ones)
    exp_q[0] = 8'h07; exp_q[1] = 8'h03;
    fork
      monitor_frames("par", 2);
      begin
        write(DATA_ADDR, exp_q[0]);
        write(DATA_ADDR, exp_q[1]);
      end
    join

    // Reset mid-DATA of 8'hFF with a byte queued, write coinciding with reset
    write(DATA_ADDR, 8'hFF);
    write(DATA_ADDR, 8'h00);
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    check("mid_tx", tx, 1'b1);
    rst  = 1'b1;
    addr = DATA_ADDR;
    we   = 1'b1;
    din  = 8'h5A;
    @(negedge clk);
    rst  = 1'b0;
    we   = 1'b0;
    addr = 16'd0;
    din  = 8'h00;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rd_hit", rd_hit, 1'b0);
    read("abort_status", STAT_ADDR, 1'b1, 8'h04);
    begin
      int lows;
      lows = 0;
      for (int k = 0; k < 3 * FB * CPB; k++) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      check("abort_no_frame", lows, 0);
    end

    // Reset while the start bit is on the line releases tx high at once
    write(DATA_ADDR, 8'h00);
    repeat (3) @(negedge clk);
    check("start_tx_low", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("start_abort_tx", tx, 1'b1);
    read("start_abort_status", STAT_ADDR, 1'b1, 8'h04);

    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
